// File: rtl/arbitro_mux_memoria.sv
// ---------------------------------------------------------------------------
// arbitro_mux_memoria
//
// Round-robin arbiter / sequencer in front of the 2:1 memory mux. Each cycle
// it decides which of two 2-bit requesters is accepted, acknowledges it
// combinationally, and registers the accepted word, the mux selector and a
// valid flag. A burst limit keeps one source from starving the other, and a
// per-source grant counter supports comparative benches.
//
// Parameters
//   BURST  max consecutive grants to one source while the other is also
//          requesting (1..15)
//   CW     width of the per-source grant counters (wrap modulo 2^CW)
//
// Ports
//   clk        in   system clock, rising edge
//   reset_L    in   asynchronous active-low reset
//   valid0     in   source 0 has a word on data_in0
//   data_in0   in   source 0 data (2 bits)
//   valid1     in   source 1 has a word on data_in1
//   data_in1   in   source 1 data (2 bits)
//   ready_out  in   downstream accepts a word this cycle
//   ack0       out  source 0 accepted this cycle (combinational)
//   ack1       out  source 1 accepted this cycle (combinational)
//   selector   out  registered index of the last accepted source
//   data_out   out  registered accepted word, held when nothing is granted
//   valid_out  out  registered, 1 when data_out was loaded on the last edge
//   grants0    out  source 0 acceptance count
//   grants1    out  source 1 acceptance count
// ---------------------------------------------------------------------------
module arbitro_mux_memoria #(
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          valid0,
  input  logic [1:0]    data_in0,
  input  logic          valid1,
  input  logic [1:0]    data_in1,
  input  logic          ready_out,
  output logic          ack0,
  output logic          ack1,
  output logic          selector,
  output logic [1:0]    data_out,
  output logic          valid_out,
  output logic [CW-1:0] grants0,
  output logic [CW-1:0] grants1
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  // Registered state
  state_t       state_q;
  logic [3:0]   bcnt_q;
  logic         selector_q;
  logic [1:0]   data_out_q;
  logic         valid_out_q;

  // Next-state values used on a grant
  state_t       state_d;
  logic [3:0]   bcnt_d;

  // Arbitration decision
  logic         grant_any;   // some source is accepted this cycle
  logic         grant_src;   // which one (meaningful only with grant_any)
  logic         burst_done;  // current owner has used up its burst
  logic         same_owner;  // grant goes to the current owner
  logic [1:0]   ack_w;
  logic [CW-1:0] grants_w [2];

  // Reset is folded in so acks drop immediately while reset_L is low.
  assign grant_any  = reset_L & ready_out & (valid0 | valid1);
  assign burst_done = (bcnt_q >= BURST_C);

  always_comb begin
    grant_src = 1'b0;
    if (valid0 && !valid1) begin
      grant_src = 1'b0;
    end else if (!valid0 && valid1) begin
      grant_src = 1'b1;
    end else begin
      // Both (or neither) valid: keep the owner until its burst is used,
      // then hand over. From IDLE source 0 wins.
      case (state_q)
        SERVE0:  grant_src = burst_done;
        SERVE1:  grant_src = ~burst_done;
        default: grant_src = 1'b0;
      endcase
    end
  end

  always_comb begin
    same_owner = ((state_q == SERVE0) && !grant_src) ||
                 ((state_q == SERVE1) &&  grant_src);
    state_d    = grant_src ? SERVE1 : SERVE0;
    bcnt_d     = 4'd1;
    if (same_owner) begin
      // Saturate so an owner served alone for a long time still reads as
      // "burst used" and yields on the first competing request.
      bcnt_d = burst_done ? BURST_C : (bcnt_q + 4'd1);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_src
      logic [CW-1:0] cnt_q;

      assign ack_w[gi] = grant_any & (grant_src == 1'(gi));

      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          cnt_q <= '0;
        end else if (ack_w[gi]) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign grants_w[gi] = cnt_q;
    end
  endgenerate

  // Arbiter FSM with its registered outputs
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      bcnt_q      <= 4'd0;
      selector_q  <= 1'b0;
      data_out_q  <= 2'b00;
      valid_out_q <= 1'b0;
    end else if (ready_out) begin
      if (grant_any) begin
        state_q     <= state_d;
        bcnt_q      <= bcnt_d;
        selector_q  <= grant_src;
        data_out_q  <= grant_src ? data_in1 : data_in0;
        valid_out_q <= 1'b1;
      end else begin
        // Nobody requesting: ownership lapses, data and selector hold.
        state_q     <= IDLE;
        bcnt_q      <= 4'd0;
        valid_out_q <= 1'b0;
      end
    end else begin
      // Backpressure: freeze arbitration, only the valid flag drops.
      valid_out_q <= 1'b0;
    end
  end

  assign ack0      = ack_w[0];
  assign ack1      = ack_w[1];
  assign selector  = selector_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign grants0   = grants_w[0];
  assign grants1   = grants_w[1];

endmodule

// File: tb/tb_arbitro_mux_memoria.sv
// ---------------------------------------------------------------------------
// tb_arbitro_mux_memoria
//
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model that tracks the current owner and the length of its
// run of consecutive grants.
// ---------------------------------------------------------------------------
module tb_arbitro_mux_memoria;

  localparam int BURST = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          valid0, valid1, ready_out;
  logic [1:0]    data_in0, data_in1;
  logic          ack0, ack1, selector, valid_out;
  logic [1:0]    data_out;
  logic [CW-1:0] grants0, grants1;

  arbitro_mux_memoria #(.BURST(BURST), .CW(CW)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .valid0    (valid0),
    .data_in0  (data_in0),
    .valid1    (valid1),
    .data_in1  (data_in1),
    .ready_out (ready_out),
    .ack0      (ack0),
    .ack1      (ack1),
    .selector  (selector),
    .data_out  (data_out),
    .valid_out (valid_out),
    .grants0   (grants0),
    .grants1   (grants1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: owner -1 means nobody owns the mux; run is the number of
  // consecutive grants the owner has received.
  int m_owner, m_run, m_sel, m_dout, m_vout, m_g0, m_g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_sel = 0; m_dout = 0; m_vout = 0; m_g0 = 0; m_g1 = 0;
  endtask

  function automatic int model_pick(bit v0, bit v1, bit rdy);
    if (!rdy || (!v0 && !v1)) return -1;
    if (v0 && !v1) return 0;
    if (!v0 && v1) return 1;
    if (m_owner < 0) return 0;
    if (m_run >= BURST) return 1 - m_owner;
    return m_owner;
  endfunction

  task automatic chk_cleared(input string tag);
    chk({tag, "_ack0"},  32'(ack0), 32'd0);
    chk({tag, "_ack1"},  32'(ack1), 32'd0);
    chk({tag, "_sel"},   32'(selector), 32'd0);
    chk({tag, "_dout"},  32'(data_out), 32'd0);
    chk({tag, "_vout"},  32'(valid_out), 32'd0);
    chk({tag, "_g0"},    32'(grants0), 32'd0);
    chk({tag, "_g1"},    32'(grants1), 32'd0);
  endtask

  // One transaction: starts and ends at a falling edge.
  task automatic cycle(input bit v0, input bit [1:0] d0, input bit v1,
                       input bit [1:0] d1, input bit rdy, output int g);
    valid0 = v0; data_in0 = d0; valid1 = v1; data_in1 = d1; ready_out = rdy;
    #1;
    g = model_pick(v0, v1, rdy);
    chk("ack0", 32'(ack0), 32'(g == 0));
    chk("ack1", 32'(ack1), 32'(g == 1));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_run   = (g == m_owner) ? m_run + 1 : 1;
      m_owner = g;
      m_sel   = g;
      m_dout  = (g == 0) ? int'(d0) : int'(d1);
      m_vout  = 1;
      if (g == 0) m_g0 = (m_g0 + 1) % (1 << CW);
      else        m_g1 = (m_g1 + 1) % (1 << CW);
    end else if (rdy) begin
      m_owner = -1; m_run = 0; m_vout = 0;
    end else begin
      m_vout = 0;
    end
    chk("selector",  32'(selector),  32'(m_sel));
    chk("data_out",  32'(data_out),  32'(m_dout));
    chk("valid_out", 32'(valid_out), 32'(m_vout));
    chk("grants0",   32'(grants0),   32'(m_g0));
    chk("grants1",   32'(grants1),   32'(m_g1));
    $display("[TB] t=%0t v0=%0d d0=%0d v1=%0d d1=%0d rdy=%0d grant=%0d sel=%0d dout=%0d vout=%0d g0=%0d g1=%0d",
             $time, v0, d0, v1, d1, rdy, g, selector, data_out, valid_out, grants0, grants1);
    @(negedge clk);
  endtask

  initial begin
    int g;
    int exp_own [10];
    exp_own = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    // Reset held for two cycles with both sources requesting
    reset_L = 1'b0;
    valid0 = 1'b1; valid1 = 1'b1; data_in0 = 2'b11; data_in1 = 2'b10; ready_out = 1'b1;
    model_reset();
    @(negedge clk);
    chk_cleared("rst_a");
    @(negedge clk);
    chk_cleared("rst_b");
    reset_L = 1'b1;  // released between edges

    // Single source 0
    cycle(1, 2'b01, 0, 2'b00, 1, g);
    cycle(1, 2'b10, 0, 2'b00, 1, g);
    cycle(1, 2'b11, 0, 2'b00, 1, g);
    chk("single_g0", 32'(grants0), 32'd3);
    chk("single_g1", 32'(grants1), 32'd0);

    // Back to IDLE, then fairness with both sources valid
    cycle(0, 2'b00, 0, 2'b00, 1, g);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 2'(i), 1, 2'(i + 1), 1, g);
      chk("fair_owner", 32'(g), 32'(exp_own[i]));
    end

    // Backpressure while SERVE1 with two grants used
    cycle(0, 2'b00, 0, 2'b00, 1, g);
    cycle(0, 2'b00, 1, 2'b01, 1, g);
    cycle(0, 2'b00, 1, 2'b10, 1, g);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'($urandom), 1, 2'($urandom), 0, g);
      chk("bp_held_dout", 32'(data_out), 32'd2);
    end
    cycle(1, 2'b01, 1, 2'b11, 1, g);
    chk("bp_resume", 32'(g), 32'd1);
    cycle(1, 2'b01, 1, 2'b00, 1, g);
    chk("bp_fourth", 32'(g), 32'd1);
    cycle(1, 2'b10, 1, 2'b01, 1, g);
    chk("bp_handover", 32'(g), 32'd0);

    // Owner served alone until saturated; competitor wins at once
    cycle(0, 2'b00, 0, 2'b00, 1, g);
    for (int i = 0; i < 6; i++) cycle(0, 2'b00, 1, 2'(i), 1, g);
    cycle(1, 2'b11, 1, 2'b01, 1, g);
    chk("sat_winner", 32'(g), 32'd0);

    // Counter wrap from a fresh reset
    reset_L = 1'b0;
    #1;
    model_reset();
    chk_cleared("rst_c");
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 17; i++) cycle(0, 2'b00, 1, 2'(i), 1, g);
    chk("wrap_g1", 32'(grants1), 32'd1);

    // Asynchronous reset mid-burst, checked before the next edge
    cycle(1, 2'b01, 1, 2'b10, 1, g);
    cycle(1, 2'b11, 1, 2'b10, 1, g);
    valid0 = 1'b1; valid1 = 1'b1; ready_out = 1'b1;
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk_cleared("rst_mid");
    @(negedge clk);
    reset_L = 1'b1;
    cycle(1, 2'b10, 1, 2'b01, 1, g);
    chk("rst_first", 32'(g), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            ($urandom_range(0, 3) != 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
